// File: rtl/pipe_stall_ctrl.sv
// Hazard stall controller for a 5-stage pipeline with a multicycle mult/div unit.
// Optional stall-cycle counter is built when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_ID,
   input  logic [4:0] rt_ID,
   input  logic       rs_use_ID,
   input  logic       rt_use_ID,
   input  logic       br_ID,
   input  logic       wr_EX,
   input  logic       ld_EX,
   input  logic [4:0] rd_EX,
   input  logic       ld_MEM,
   input  logic [4:0] rd_MEM,
   input  logic       md_start_EX,
   input  logic       md_div_EX,
   input  logic       md_use_ID,
`ifdef STALL_PERF_CNT_EN
   output logic [31:0] stall_cycles,
`endif
   output logic       En_PC,
   output logic       En_IF_ID,
   output logic       Clr_ID_EX,
   output logic       md_busy
);

   // state | meaning
   // IDLE  | mult/div unit free, accepts md_start_EX
   // BUSY  | computing; cnt holds remaining busy cycles
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       stall;
   logic       hz_ld_ex, hz_br_ex, hz_br_mem, hz_md;

   function automatic logic match(input logic [4:0] r,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic rs_use, input logic rt_use,
                                  input logic br);
      match = (r != 5'd0) &&
              ((((rs_use || br) && (rs == r))) || (((rt_use || br) && (rt == r))));
   endfunction

   assign md_busy = (state == BUSY);

   always_comb begin
      hz_ld_ex  = ld_EX && match(rd_EX, rs_ID, rt_ID, rs_use_ID, rt_use_ID, br_ID);
      hz_br_ex  = br_ID && wr_EX && match(rd_EX, rs_ID, rt_ID, rs_use_ID, rt_use_ID, br_ID);
      hz_br_mem = br_ID && ld_MEM && match(rd_MEM, rs_ID, rt_ID, rs_use_ID, rt_use_ID, br_ID);
      hz_md     = md_use_ID && (md_busy || md_start_EX);
      // Held in reset the pipeline must free-run, so hazards are masked.
      stall     = reset && (hz_ld_ex || hz_br_ex || hz_br_mem || hz_md);
      En_PC     = ~stall;
      En_IF_ID  = ~stall;
      Clr_ID_EX = stall;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (md_start_EX) begin
               cnt_nxt   = md_div_EX ? 4'd10 : 4'd5;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1)
               state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

`ifdef STALL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset)
         stall_cycles <= 32'd0;
      else if (stall && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; outputs compared as {En_PC,En_IF_ID,Clr_ID_EX,md_busy}.
module tb_pipe_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_ID, rt_ID, rd_EX, rd_MEM;
   logic       rs_use_ID, rt_use_ID, br_ID, wr_EX, ld_EX, ld_MEM;
   logic       md_start_EX, md_div_EX, md_use_ID;
   logic       En_PC, En_IF_ID, Clr_ID_EX, md_busy;
`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   int vec = 0;
   int err = 0;

   localparam logic [3:0] RUN      = 4'b1100;
   localparam logic [3:0] STALL    = 4'b0010;
   localparam logic [3:0] BUSY_RUN = 4'b1101;
   localparam logic [3:0] BUSY_STL = 4'b0011;

   wire [3:0] outs = {En_PC, En_IF_ID, Clr_ID_EX, md_busy};

   always #5 clk = ~clk;

   pipe_stall_ctrl dut (
      .clk(clk), .reset(reset),
      .rs_ID(rs_ID), .rt_ID(rt_ID),
      .rs_use_ID(rs_use_ID), .rt_use_ID(rt_use_ID),
      .br_ID(br_ID), .wr_EX(wr_EX), .ld_EX(ld_EX), .rd_EX(rd_EX),
      .ld_MEM(ld_MEM), .rd_MEM(rd_MEM),
      .md_start_EX(md_start_EX), .md_div_EX(md_div_EX), .md_use_ID(md_use_ID),
`ifdef STALL_PERF_CNT_EN
      .stall_cycles(stall_cycles),
`endif
      .En_PC(En_PC), .En_IF_ID(En_IF_ID), .Clr_ID_EX(Clr_ID_EX), .md_busy(md_busy)
   );

   task automatic clear_inputs();
      rs_ID = 0; rt_ID = 0; rd_EX = 0; rd_MEM = 0;
      rs_use_ID = 0; rt_use_ID = 0; br_ID = 0; wr_EX = 0; ld_EX = 0; ld_MEM = 0;
      md_start_EX = 0; md_div_EX = 0; md_use_ID = 0;
   endtask

   // advance to the next cycle: inputs are driven 1 time unit after the edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      next_cycle();
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL reset_idle got=%b exp=%b", outs, RUN); end
      next_cycle();
      ld_EX = 1; rd_EX = 8; rs_use_ID = 1; rs_ID = 8; md_use_ID = 1; md_start_EX = 1;
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL reset_masks_hazard got=%b exp=%b", outs, RUN); end
`ifdef STALL_PERF_CNT_EN
      vec++;
      if (stall_cycles !== 32'd0) begin err++; $display("FAIL reset_perf got=%0d exp=0", stall_cycles); end
`endif
      next_cycle();
      vec++;
      if (md_busy !== 1'b0) begin err++; $display("FAIL reset_ignores_start got=%b exp=0", md_busy); end
      clear_inputs();
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_load_use();
      clear_inputs();
      ld_EX = 1; rd_EX = 8; rs_use_ID = 1; rs_ID = 8;
      @(negedge clk);
      vec++;
      if (outs !== STALL) begin err++; $display("FAIL load_use_stall got=%b exp=%b", outs, STALL); end
      next_cycle();
      ld_EX = 0;
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL load_use_clear got=%b exp=%b", outs, RUN); end
`ifdef STALL_PERF_CNT_EN
      vec++;
      if (stall_cycles !== 32'd1) begin err++; $display("FAIL perf_one got=%0d exp=1", stall_cycles); end
`endif
      // load feeding rt with rt not used: no hazard
      ld_EX = 1; rd_EX = 8; rs_use_ID = 0; rt_ID = 8; rt_use_ID = 0;
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL load_unused_rt got=%b exp=%b", outs, RUN); end
      next_cycle();
      clear_inputs();
      ld_EX = 1; rd_EX = 12; rt_use_ID = 1; rt_ID = 12;
      @(negedge clk);
      vec++;
      if (outs !== STALL) begin err++; $display("FAIL load_use_rt got=%b exp=%b", outs, STALL); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_branch();
      clear_inputs();
      br_ID = 1; rt_ID = 9; wr_EX = 1; rd_EX = 9;
      @(negedge clk);
      vec++;
      if (outs !== STALL) begin err++; $display("FAIL br_after_alu got=%b exp=%b", outs, STALL); end
      next_cycle();
      wr_EX = 0; rd_EX = 0; ld_MEM = 1; rd_MEM = 9;
      @(negedge clk);
      vec++;
      if (outs !== STALL) begin err++; $display("FAIL br_after_load_mem got=%b exp=%b", outs, STALL); end
      next_cycle();
      ld_MEM = 0;
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL br_clear got=%b exp=%b", outs, RUN); end
      next_cycle();
      // non-branch EX-use reader of an ALU or MEM-load result is forwarded, not stalled
      clear_inputs();
      rt_use_ID = 1; rt_ID = 9; wr_EX = 1; rd_EX = 9; ld_MEM = 1; rd_MEM = 9;
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL alu_forward got=%b exp=%b", outs, RUN); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_zero_reg();
      clear_inputs();
      ld_EX = 1; rd_EX = 0; rs_ID = 0; rs_use_ID = 1;
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL zero_load got=%b exp=%b", outs, RUN); end
      next_cycle();
      clear_inputs();
      br_ID = 1; wr_EX = 1; rd_EX = 0; ld_MEM = 1; rd_MEM = 0;
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL zero_branch got=%b exp=%b", outs, RUN); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_mult();
      clear_inputs();
      md_start_EX = 1; md_div_EX = 0;
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL mult_issue got=%b exp=%b", outs, RUN); end
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         // a divide issued mid-busy must be ignored
         md_start_EX = (k == 2); md_div_EX = (k == 2);
         @(negedge clk);
         vec++;
         if (outs !== BUSY_RUN) begin err++; $display("FAIL mult_busy_%0d got=%b exp=%b", k, outs, BUSY_RUN); end
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL mult_done got=%b exp=%b", outs, RUN); end
      next_cycle();
   endtask

   task automatic test_divide();
      clear_inputs();
      md_start_EX = 1; md_div_EX = 1; md_use_ID = 1;
      @(negedge clk);
      vec++;
      if (outs !== STALL) begin err++; $display("FAIL div_issue got=%b exp=%b", outs, STALL); end
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         md_start_EX = 0; md_div_EX = 0;
         @(negedge clk);
         vec++;
         if (outs !== BUSY_STL) begin err++; $display("FAIL div_busy_%0d got=%b exp=%b", k, outs, BUSY_STL); end
      end
      next_cycle();
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL div_done got=%b exp=%b", outs, RUN); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_reset_mid_busy();
      clear_inputs();
      md_start_EX = 1; md_use_ID = 1;
      next_cycle();
      md_start_EX = 0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      vec++;
      if (outs !== BUSY_STL) begin err++; $display("FAIL mid_busy3 got=%b exp=%b", outs, BUSY_STL); end
      reset = 1'b0;
      next_cycle();
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL mid_reset got=%b exp=%b", outs, RUN); end
`ifdef STALL_PERF_CNT_EN
      vec++;
      if (stall_cycles !== 32'd0) begin err++; $display("FAIL mid_reset_perf got=%0d exp=0", stall_cycles); end
`endif
      reset = 1'b1;
      clear_inputs();
      next_cycle();
      @(negedge clk);
      vec++;
      if (outs !== RUN) begin err++; $display("FAIL post_reset_idle got=%b exp=%b", outs, RUN); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_zero_reg();
      test_mult();
      test_divide();
      test_reset_mid_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have ports rs_ID and rt_ID, input, 5 bits each: source register numbers of the instruction in ID.
REQ-004 SHALL have ports rs_use_ID and rt_use_ID, input, 1 bit each: the ID instruction reads rs or rt in EX (Tuse=1).
REQ-005 SHALL have port br_ID, input, 1 bit: the ID instruction is a branch or jr that reads its used operands in ID (Tuse=0).
REQ-006 SHALL have ports wr_EX (input, 1 bit), ld_EX (input, 1 bit) and rd_EX (input, 5 bits): the EX instruction writes the GPR rd_EX; ld_EX marks a load.
REQ-007 SHALL have ports ld_MEM (input, 1 bit) and rd_MEM (input, 5 bits): the MEM-stage instruction is a load targeting rd_MEM.
REQ-008 SHALL have ports md_start_EX (input, 1 bit) and md_div_EX (input, 1 bit): a mult/div issues in EX; md_div_EX=1 means divide.
REQ-009 SHALL have port md_use_ID, input, 1 bit: the ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have ports En_PC and En_IF_ID, output, 1 bit each: write enables of the PC and the IF/ID register.
REQ-011 SHALL have port Clr_ID_EX, output, 1 bit: loads a bubble (all zero) into ID/EX on the next edge.
REQ-012 SHALL have port md_busy, output, 1 bit: the mult/div unit is computing.

Function
REQ-013 SHALL define match(r) = (r!=0) && ((rs_use_ID||br_ID)&&rs_ID==r || (rt_use_ID||br_ID)&&rt_ID==r).
REQ-014 SHALL assert stall when any of the following holds: ld_EX && match(rd_EX); br_ID && wr_EX && match(rd_EX); br_ID && ld_MEM && match(rd_MEM); md_use_ID && (md_busy || md_start_EX).
REQ-015 SHALL drive En_PC = En_IF_ID = ~stall and Clr_ID_EX = stall, combinationally, in the same cycle.
REQ-016 SHALL implement a two-state FSM with states IDLE and BUSY and a 4-bit down-counter cnt.
REQ-017 SHALL, in IDLE with md_start_EX=1, load cnt with 5 for mult or 10 for div and move to BUSY on the next edge.
REQ-018 SHALL, in BUSY, decrement cnt every cycle and return to IDLE on the edge at which cnt==1, so md_busy is high for exactly 5 (mult) or 10 (div) cycles starting the cycle after issue.
REQ-019 SHALL drive md_busy = (state==BUSY).
REQ-020 SHALL ignore md_start_EX while in BUSY: no counter reload and no state change.
REQ-021 SHALL treat register 0 as never hazarding, regardless of the use flags.

Reset
REQ-022 SHALL, when reset=0 at a rising edge, enter IDLE with cnt=0 and any statistics counter cleared, including when reset is applied mid-BUSY.
REQ-023 SHALL, while reset=0, drive En_PC=1, En_IF_ID=1, Clr_ID_EX=0 and md_busy=0 on the cycle following the reset edge.

Configuration
REQ-024 SHALL, when STALL_PERF_CNT_EN is defined, add output stall_cycles (32 bits) that increments on each cycle with stall=1 while reset=1 and saturates at 0xFFFFFFFF.
REQ-025 SHALL, when STALL_PERF_CNT_EN is not defined, omit the stall_cycles port and its counter entirely; all other behaviour is unchanged.

Verification
REQ-026 Bench SHALL cover load-use: ld_EX=1, rd_EX=8, rs_use_ID=1, rs_ID=8 -> one cycle with En_PC=0, En_IF_ID=0, Clr_ID_EX=1; then ld_EX=0 -> stall clears.
REQ-027 Bench SHALL cover branch after ALU: br_ID=1, rt_ID=9, wr_EX=1, rd_EX=9 -> stall; the next cycle ld_MEM=1, rd_MEM=9 -> stall; the following cycle ld_MEM=0 -> no stall.
REQ-028 Bench SHALL cover the $0 case: ld_EX=1, rd_EX=0, rs_ID=0, rs_use_ID=1 -> no stall.
REQ-029 Bench SHALL cover divide: md_start_EX=1, md_div_EX=1 at cycle N -> md_busy=1 for cycles N+1..N+10; md_use_ID=1 throughout -> Clr_ID_EX=1 for cycles N..N+10 and 0 at N+11.
REQ-030 Bench SHALL cover reset mid-operation: mult issued, reset=0 at the third busy cycle -> md_busy=0 and no stall on the next cycle; with STALL_PERF_CNT_EN defined, stall_cycles=0.
